// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, rcon table, key-scheduler state
// encoding and byte-level helpers used by the key-step and sbox logic.
package aes_pkg;

   localparam int unsigned NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_SERVE  = 2'd2
   } state_e;

   // Round constant byte for round index 0..9; anything else yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd0:    r = 8'h01;
         4'd1:    r = 8'h02;
         4'd2:    r = 8'h04;
         4'd3:    r = 8'h08;
         4'd4:    r = 8'h10;
         4'd5:    r = 8'h20;
         4'd6:    r = 8'h40;
         4'd7:    r = 8'h80;
         4'd8:    r = 8'h1b;
         4'd9:    r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // RotWord: one-byte left rotation; the front half of SubWord(RotWord(x))
   // shared by the forward and inverse steps.
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // AES S-box: multiplicative inverse (a^254, 0 maps to 0) then affine map.
   function automatic logic [7:0] sbox_byte(input logic [7:0] a);
      localparam logic [7:0] INV_EXP = 8'hfe;
      logic [7:0]  inv;
      logic [15:0] d;
      inv = 8'h01;
      for (int unsigned i = 0; i < 8; i++) begin
         inv = gf_mul(inv, inv);
         if (INV_EXP[3'(7 - i)]) inv = gf_mul(inv, a);
      end
      d = {inv, inv};
      return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step in either direction (combinational).
// dir_i=0: forward step to the next round key; dir_i=1: inverse step back
// to the previous round key. One set of four S-boxes serves both directions.
module aes_key_step
   import aes_pkg::*;
(
   input  logic         dir_i,
   input  logic [3:0]   rcon_idx_i,
   input  logic [127:0] word_i,
   output logic [127:0] word_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] sub_in, rot, sub, t;

   assign w0 = word_i[127:96];
   assign w1 = word_i[95:64];
   assign w2 = word_i[63:32];
   assign w3 = word_i[31:0];

   // The inverse step needs SubWord of the recovered previous w3 (w3^w2).
   assign sub_in = dir_i ? (w3 ^ w2) : w3;
   assign rot    = rot_word(sub_in);

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (rot[8*i +: 8]),
         .out_o (sub[8*i +: 8])
      );
   end

   assign t = sub ^ {rcon(rcon_idx_i), 24'h000000};

   // Chain the word XORs forward or backward depending on direction.
   always_comb begin
      word_o = '0;
      if (dir_i) begin
         word_o[31:0]   = w3 ^ w2;
         word_o[63:32]  = w2 ^ w1;
         word_o[95:64]  = w1 ^ w0;
         word_o[127:96] = w0 ^ t;
      end else begin
         word_o[127:96] = w0 ^ t;
         word_o[95:64]  = w1 ^ w0 ^ t;
         word_o[63:32]  = w2 ^ w1 ^ w0 ^ t;
         word_o[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ t;
      end
   end

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box (combinational).
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   assign out_o = sbox_byte(in_i);

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 decryption key scheduler: expands the cipher key to
// round key 10, then steps backward one round key per rk_next.
// Optional feature macro: AES_INV_KEY_CACHE_EN (keeps round key 10 for a
// one-cycle rewind instead of re-expanding).
module aes_inv_key_sched
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   output logic         rk_valid,
   input  logic         rk_next,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         busy
);

   localparam logic [3:0] LAST_CNT = 4'(NR - 1);
   localparam logic [3:0] TOP_RND  = 4'(NR);

   state_e       state_q, state_d;
   logic [127:0] work_q, work_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [3:0]   rk_round_q, rk_round_d;
   logic         rk_valid_q, rk_valid_d;
   logic         busy_q, busy_d;
   logic         load;
   logic         step_dir;
   logic [3:0]   step_idx;
   logic [127:0] step_word;
`ifdef AES_INV_KEY_CACHE_EN
   logic [127:0] cache_q, cache_d;
`endif

   assign key_ready = (state_q != ST_EXPAND);
   assign load      = key_valid && key_ready;
   assign rk        = work_q;
   assign rk_round  = rk_round_q;
   assign rk_valid  = rk_valid_q;
   assign busy      = busy_q;

   assign step_dir = (state_q == ST_SERVE);
   assign step_idx = step_dir ? (rk_round_q - 4'd1) : cnt_q;

   aes_key_step u_step (
      .dir_i      (step_dir),
      .rcon_idx_i (step_idx),
      .word_i     (work_q),
      .word_o     (step_word)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         work_q     <= '0;
         cnt_q      <= '0;
         rk_round_q <= '0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
         cache_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         rk_round_q <= rk_round_d;
         rk_valid_q <= rk_valid_d;
         busy_q     <= busy_d;
`ifdef AES_INV_KEY_CACHE_EN
         cache_q    <= cache_d;
`endif
      end
   end

   // Next-state logic; a key load overrides whatever SERVE would have done.
   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      rk_round_d = rk_round_q;
      rk_valid_d = rk_valid_q;
      busy_d     = busy_q;
`ifdef AES_INV_KEY_CACHE_EN
      cache_d    = cache_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
         end
         ST_EXPAND: begin
            work_d = step_word;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               state_d    = ST_SERVE;
               rk_round_d = TOP_RND;
               rk_valid_d = 1'b1;
               busy_d     = 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
               cache_d    = step_word;
`endif
            end
         end
         ST_SERVE: begin
            if (rk_next) begin
               if (rk_round_q != 4'd0) begin
                  work_d     = step_word;
                  rk_round_d = rk_round_q - 4'd1;
               end else begin
`ifdef AES_INV_KEY_CACHE_EN
                  work_d     = cache_q;
                  rk_round_d = TOP_RND;
`else
                  // work holds the cipher key at round 0: just re-expand it.
                  state_d    = ST_EXPAND;
                  cnt_d      = '0;
                  busy_d     = 1'b1;
                  rk_valid_d = 1'b0;
`endif
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         state_d    = ST_EXPAND;
         work_d     = key;
         cnt_d      = '0;
         busy_d     = 1'b1;
         rk_valid_d = 1'b0;
      end
   end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Iterative AES-128 decryption key scheduler. It accepts a 128-bit cipher key and runs the forward expansion for 10 cycles to reach round key 10. It then walks the schedule backward, one round key per request, in the order the inverse cipher consumes them (10 down to 0). It pairs with the decrypt datapath the same way the forward key memory pairs with the encrypt datapath, without storing all 11 round keys.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous reset, active low
- key_valid  input  1  cipher key offered
- key_ready  output  1  key can be accepted (high in IDLE and SERVE)
- key  input  128  cipher key, word0 in [127:96]
- rk_valid  output  1  rk/rk_round hold a valid round key
- rk_next  input  1  consumer done with current rk; step to next
- rk  output  128  current round key, registered
- rk_round  output  4  index of rk (10..0)
- busy  output  1  high in EXPAND

## Operation
- States: IDLE, EXPAND, SERVE.
- Load: key_valid && key_ready at an edge: work <= key, cnt <= 0, state <= EXPAND. Accepted from IDLE or SERVE. In SERVE this aborts the current walk.
- EXPAND: each edge work <= fwd(work, rcon(cnt)), cnt++.
  - fwd is the standard step: t = SubWord(RotWord(w3)) ^ rcon; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - On the edge where cnt==9: state <= SERVE, rk_round <= 10.
- SERVE: rk_valid=1, rk=work.
  - rk_next with rk_round>0: work <= inv(work, rcon(rk_round-1)), rk_round--.
  - inv is the inverse step: w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
- Rewind: rk_next with rk_round==0 returns to round 10 for the next block; see Configuration.
- rcon(i) for i=0..9: 01,02,04,08,10,20,40,80,1b,36 in byte [31:24]; all other values give 0.
- rk_next outside SERVE is ignored. key_valid while busy is not accepted (key_ready=0).
- Simultaneous key accept and rk_next in SERVE: the load wins and rk_next is dropped.
- Reset, including mid-EXPAND or mid-walk: state IDLE; work, cnt and cache cleared.
  - Reset values: rk=0, rk_round=0, rk_valid=0, busy=0, key_ready=1 (combinational from IDLE).

## Timing
- Key accepted at edge N. busy is high after edges N..N+9. rk_valid=1 with rk_round=10 after edge N+10. Load latency is 10 cycles.
- Throughput in SERVE is one round key per cycle. rk updates on the edge after rk_next is sampled, and rk_valid stays high throughout the walk.
- rk_valid, rk, rk_round and busy are registered.
- key_ready = (state != EXPAND) and is combinational from state.
- Rewind latency is 1 cycle with the cache and 10 cycles without it.

## Configuration
- AES_INV_KEY_CACHE_EN defined:
  - A 128-bit cache register captures round key 10 when EXPAND completes.
  - Rewind from round 0: work <= cache, rk_round <= 10 in one edge, and rk_valid stays high.
- Undefined:
  - No cache register.
  - Rewind from round 0 re-enters EXPAND from work, which equals the cipher key at round 0. busy goes high, rk_valid goes low, and the same 10-cycle load latency applies.

## Structure
- Shared package aes_pkg holds:
  - the round count constant NR=10
  - the rcon function
  - the state encoding (IDLE/EXPAND/SERVE)
- Both fwd and inv need SubWord(RotWord(x)); the shared package defines one function for both.
- SubWord uses the codebase's existing sbox module, 4 instances total, shared between directions through a muxed input word.
- Natural sub-module: aes_key_step, combinational.
  - Inputs: dir, rcon index, 128-bit word.
  - Output: the next 128-bit word.
  - Contains the 4 sbox instances.

## Test plan
- FIPS-197 load: key 2b7e151628aed2a6abf7158809cf4f3c → busy for 10 cycles, then rk_valid, rk_round=10, rk=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse walk: pulse rk_next continuously from the state above.
  - Round 9 must be ac7766f319fadc2128d12941575c006e.
  - Round 1 must be a0fafe1788542cb123a339392a6c7605.
  - Round 0 must be 2b7e151628aed2a6abf7158809cf4f3c.
  - Exactly 10 cycles from round 10 to round 0.
- Rewind at round 0:
  - With AES_INV_KEY_CACHE_EN: one cycle later rk_round=10, rk=d014…0ca6, rk_valid never drops.
  - Without the macro: rk_valid low for 10 cycles, then the same values.
- Load during walk: at rk_round=5, assert key_valid=1 with key=000102030405060708090a0b0c0d0e0f and rk_next=1 in the same cycle → load wins. After 10 cycles rk=13111d7fe3944a17f307a78b4d2b30c5 with rk_round=10.
- Reset mid-EXPAND: drop rst_n at cycle 4 of EXPAND → all outputs read their reset values, state IDLE. A fresh load produces the correct round-10 key.
- Ignored inputs:
  - key_valid during EXPAND: key_ready=0, the key is not taken and the original expansion result is unchanged.
  - rk_next in IDLE: no change to any output.
